// File: rtl/riscv_core_dcache_axi_refill.sv
// D-cache line-fill and victim-writeback engine driving a 64-bit AXI4 master port.
// Define DCACHE_REFILL_WB_EN to build the dirty-victim writeback path (AW/W/B).
module riscv_core_dcache_axi_refill #(
    parameter int ADDR_WIDTH     = 32,
    parameter int LINE_WIDTH     = 256,
    parameter int AXI_DATA_WIDTH = 64
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,

    input  logic                        i_miss_req,
    input  logic [ADDR_WIDTH-1:0]       i_miss_addr,
    input  logic                        i_victim_dirty,
    input  logic [ADDR_WIDTH-1:0]       i_victim_addr,
    input  logic [LINE_WIDTH-1:0]       i_victim_line,
    output logic                        o_busy,
    output logic                        o_refill_done,
    output logic [LINE_WIDTH-1:0]       o_refill_line,
    output logic                        o_refill_err,

    output logic                        o_arvalid,
    input  logic                        i_arready,
    output logic [ADDR_WIDTH-1:0]       o_araddr,
    output logic [7:0]                  o_arlen,
    output logic [2:0]                  o_arsize,
    output logic [1:0]                  o_arburst,

    input  logic                        i_rvalid,
    output logic                        o_rready,
    input  logic [AXI_DATA_WIDTH-1:0]   i_rdata,
    input  logic [1:0]                  i_rresp,
    input  logic                        i_rlast,

    output logic                        o_awvalid,
    input  logic                        i_awready,
    output logic [ADDR_WIDTH-1:0]       o_awaddr,
    output logic [7:0]                  o_awlen,
    output logic [2:0]                  o_awsize,
    output logic [1:0]                  o_awburst,

    output logic                        o_wvalid,
    input  logic                        i_wready,
    output logic [AXI_DATA_WIDTH-1:0]   o_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] o_wstrb,
    output logic                        o_wlast,

    input  logic                        i_bvalid,
    output logic                        o_bready,
    input  logic [1:0]                  i_bresp
);

    localparam int BEATS = LINE_WIDTH / AXI_DATA_WIDTH;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(LINE_WIDTH / 8 - 1);
    localparam logic [7:0]            BURST_LEN  = 8'(BEATS - 1);
    localparam logic [2:0]            BURST_SIZE = 3'($clog2(AXI_DATA_WIDTH / 8));
    localparam logic [1:0]            BURST_INCR = 2'b01;

    typedef enum logic [2:0] {
        IDLE,
        WB_AW,
        WB_W,
        WB_B,
        RD_AR,
        RD_R,
        DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] beat_cnt;
    logic [CNT_W-1:0] next_beat;
    logic             rlast_bad;

    assign next_beat = beat_cnt + CNT_W'(1);
    assign rlast_bad = (i_rlast != (beat_cnt == LAST_BEAT));

    function automatic logic [ADDR_WIDTH-1:0] line_align(input logic [ADDR_WIDTH-1:0] addr);
        return addr & LINE_MASK;
    endfunction

    // Burst shape is fixed: every transfer is one whole line in INCR beats.
    assign o_arlen   = BURST_LEN;
    assign o_arsize  = BURST_SIZE;
    assign o_arburst = BURST_INCR;
    assign o_awlen   = BURST_LEN;
    assign o_awsize  = BURST_SIZE;
    assign o_awburst = BURST_INCR;

`ifdef DCACHE_REFILL_WB_EN
    logic [LINE_WIDTH-1:0] victim_q;
    logic                  unused_inputs;

    assign o_wstrb       = '1;
    assign unused_inputs = ^{i_rresp[0], i_bresp[0]};
`else
    logic unused_inputs;

    assign o_awvalid     = 1'b0;
    assign o_awaddr      = '0;
    assign o_wvalid      = 1'b0;
    assign o_wdata       = '0;
    assign o_wstrb       = '0;
    assign o_wlast       = 1'b0;
    assign o_bready      = 1'b0;
    assign unused_inputs = ^{i_victim_dirty, i_victim_addr, i_victim_line,
                             i_awready, i_wready, i_bvalid, i_bresp, i_rresp[0]};
`endif

    // NOTE: reset is synchronous and every register, including the 256-bit
    // assembled line, is cleared by it; all state updates are non-blocking.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state         <= IDLE;
            beat_cnt      <= '0;
            o_busy        <= 1'b0;
            o_refill_done <= 1'b0;
            o_refill_err  <= 1'b0;
            o_refill_line <= '0;
            o_arvalid     <= 1'b0;
            o_araddr      <= '0;
            o_rready      <= 1'b0;
`ifdef DCACHE_REFILL_WB_EN
            victim_q      <= '0;
            o_awvalid     <= 1'b0;
            o_awaddr      <= '0;
            o_wvalid      <= 1'b0;
            o_wdata       <= '0;
            o_wlast       <= 1'b0;
            o_bready      <= 1'b0;
`endif
        end else begin
            o_refill_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_miss_req) begin
                        o_busy       <= 1'b1;
                        o_refill_err <= 1'b0;
                        o_araddr     <= line_align(i_miss_addr);
                        beat_cnt     <= '0;
`ifdef DCACHE_REFILL_WB_EN
                        victim_q     <= i_victim_line;
                        o_awaddr     <= line_align(i_victim_addr);
                        if (i_victim_dirty) begin
                            state     <= WB_AW;
                            o_awvalid <= 1'b1;
                        end else begin
                            state     <= RD_AR;
                            o_arvalid <= 1'b1;
                        end
`else
                        state        <= RD_AR;
                        o_arvalid    <= 1'b1;
`endif
                    end
                end

`ifdef DCACHE_REFILL_WB_EN
                WB_AW: begin
                    // W data is only offered once the address has been accepted.
                    if (i_awready) begin
                        state     <= WB_W;
                        o_awvalid <= 1'b0;
                        o_wvalid  <= 1'b1;
                        o_wdata   <= victim_q[AXI_DATA_WIDTH-1:0];
                        o_wlast   <= (LAST_BEAT == '0);
                        beat_cnt  <= '0;
                    end
                end

                WB_W: begin
                    if (i_wready) begin
                        if (beat_cnt == LAST_BEAT) begin
                            state    <= WB_B;
                            o_wvalid <= 1'b0;
                            o_wlast  <= 1'b0;
                            o_bready <= 1'b1;
                        end else begin
                            beat_cnt <= next_beat;
                            o_wdata  <= victim_q[next_beat*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
                            o_wlast  <= (next_beat == LAST_BEAT);
                        end
                    end
                end

                WB_B: begin
                    if (i_bvalid) begin
                        state        <= RD_AR;
                        o_bready     <= 1'b0;
                        o_arvalid    <= 1'b1;
                        o_refill_err <= o_refill_err | i_bresp[1];
                    end
                end
`endif

                RD_AR: begin
                    if (i_arready) begin
                        state     <= RD_R;
                        o_arvalid <= 1'b0;
                        o_rready  <= 1'b1;
                        beat_cnt  <= '0;
                    end
                end

                RD_R: begin
                    // Beat count, not RLAST, ends the burst so a bad RLAST cannot truncate the line.
                    if (i_rvalid) begin
                        o_refill_line[beat_cnt*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] <= i_rdata;
                        o_refill_err <= o_refill_err | i_rresp[1] | rlast_bad;
                        if (beat_cnt == LAST_BEAT) begin
                            state         <= DONE;
                            o_rready      <= 1'b0;
                            o_refill_done <= 1'b1;
                        end else begin
                            beat_cnt <= next_beat;
                        end
                    end
                end

                DONE: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end

                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
